// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types for the two-port memory arbiter.
//   state_t    - arbiter FSM states (IDLE, BUSY)
//   port_idx_t - requester index (0 = core, 1 = loader/DMA/debug)
//   mem_req_t  - one requester's request fields, bundled
package memory_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic MEMORY_COMMAND_READ  = 1'b0;
  localparam logic MEMORY_COMMAND_WRITE = 1'b1;

  typedef logic port_idx_t;

  typedef struct packed {
    logic        enable;
    logic        command;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] write_mask;
  } mem_req_t;
endpackage

// File: rtl/arbiter_grant.sv
// arbiter_grant: combinational 2-way grant.
//   req  in  2 : request bits, bit N = port N
//   last in  1 : port that won the most recent accept
//   gnt  out 2 : one-hot grant (all zero when nobody requests)
// MEMORY_ARBITER_ROUND_ROBIN_EN defined : contention goes to the port that did
//   not win last. Undefined : port 0 always wins contention.
module arbiter_grant
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    if (req == 2'b11) gnt = (last == 1'b0) ? 2'b10 : 2'b01;
    else              gnt = req;
`else
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
`endif
  end

`ifndef MEMORY_ARBITER_ROUND_ROBIN_EN
  // fixed priority never looks at the last winner
  logic unused_last;
  assign unused_last = last;
`endif
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between two requesters (port 0 core,
// port 1 loader/DMA/debug) with at most one transaction in flight.
//   TIMEOUT_CYCLES          : BUSY cycles allowed before abort, 0 = no watchdog
//   clk, reset              : clock, async active-high reset
//   portN_memory_*  (N=0,1) : requester side request in, ready/valid/data out
//   memory_*                : downstream request out, ready/valid/data in
//   timeout_error           : one-cycle pulse the cycle after a watchdog abort
//   owner                   : port of the in-flight / most recent transaction
// MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin contention (else fixed).
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        port0_memory_enable,
  input  logic        port0_memory_command,
  input  logic [31:0] port0_read_memory_address,
  input  logic [31:0] port0_write_memory_address,
  input  logic [31:0] port0_write_memory_data,
  input  logic [31:0] port0_write_memory_mask,
  output logic        port0_memory_ready,
  output logic        port0_memory_valid,
  output logic [31:0] port0_read_memory_data,
  input  logic        port1_memory_enable,
  input  logic        port1_memory_command,
  input  logic [31:0] port1_read_memory_address,
  input  logic [31:0] port1_write_memory_address,
  input  logic [31:0] port1_write_memory_data,
  input  logic [31:0] port1_write_memory_mask,
  output logic        port1_memory_ready,
  output logic        port1_memory_valid,
  output logic [31:0] port1_read_memory_data,
  output logic        memory_enable,
  output logic        memory_command,
  output logic [31:0] read_memory_address,
  output logic [31:0] write_memory_address,
  output logic [31:0] write_memory_data,
  output logic [31:0] write_memory_mask,
  input  logic        memory_ready,
  input  logic        memory_valid,
  input  logic [31:0] read_memory_data,
  output logic        timeout_error,
  output port_idx_t   owner
);
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  mem_req_t         req0, req1, cur;
  logic [1:0]       gnt;
  port_idx_t        last, sel;
  logic             busy, accept, done, abort;

  assign req0 = {port0_memory_enable, port0_memory_command, port0_read_memory_address,
                 port0_write_memory_address, port0_write_memory_data, port0_write_memory_mask};
  assign req1 = {port1_memory_enable, port1_memory_command, port1_read_memory_address,
                 port1_write_memory_address, port1_write_memory_data, port1_write_memory_mask};

  arbiter_grant u_grant (
    .req  ({req1.enable, req0.enable}),
    .last (last),
    .gnt  (gnt)
  );

  assign busy = (state == BUSY);
  // IDLE: granted port drives memory; BUSY: owner's fields stay on the bus
  assign sel  = busy ? owner : gnt[1];
  assign cur  = sel ? req1 : req0;

  assign memory_enable        = !busy && (gnt != 2'b00);
  assign memory_command       = cur.command;
  assign read_memory_address  = cur.read_address;
  assign write_memory_address = cur.write_address;
  assign write_memory_data    = cur.write_data;
  assign write_memory_mask    = cur.write_mask;

  assign accept = memory_enable && memory_ready;
  assign done   = busy && memory_valid;
  // completion from memory wins over the watchdog in the same cycle
  assign abort  = WDOG_EN && busy && !memory_valid && (cnt == LIMIT);

  assign port0_memory_ready = !busy && gnt[0] && memory_ready;
  assign port1_memory_ready = !busy && gnt[1] && memory_ready;
  assign port0_memory_valid = (done || abort) && (owner == 1'b0);
  assign port1_memory_valid = (done || abort) && (owner == 1'b1);
  assign port0_read_memory_data = (done && owner == 1'b0) ? read_memory_data : '0;
  assign port1_read_memory_data = (done && owner == 1'b1) ? read_memory_data : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = BUSY;
      BUSY:    if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      cnt           <= '0;
      timeout_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      timeout_error <= abort;
      if (accept) begin
        owner <= sel;
        cnt   <= '0;
      end else if (busy && !memory_valid && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // reset to 1 so port 0 wins the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last <= 1'b1;
    else if (accept) last <= sel;
  end
`else
  assign last = 1'b1;
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized + directed bench for memory_arbiter with a
// transaction-level reference model; expected accepts, responses, forwarded
// requests and timeouts are queued by the stimulus and popped by a monitor.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int TMO = 4;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct { int cyc; int port; logic [31:0] data; } ev_t;
  typedef struct { int cyc; logic en; logic cmd; logic [31:0] ra, wa, wd, wm; } fwd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_en [2];
  logic        p_cmd[2];
  logic [31:0] p_ra [2], p_wa[2], p_wd[2], p_wm[2];
  logic        rdy0, rdy1, vld0, vld1;
  logic [31:0] rd0, rd1;
  logic        memory_enable, memory_command;
  logic [31:0] read_memory_address, write_memory_address, write_memory_data, write_memory_mask;
  logic        memory_ready, memory_valid;
  logic [31:0] read_memory_data;
  logic        timeout_error;
  logic        owner;

  memory_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .port0_memory_enable(p_en[0]), .port0_memory_command(p_cmd[0]),
    .port0_read_memory_address(p_ra[0]), .port0_write_memory_address(p_wa[0]),
    .port0_write_memory_data(p_wd[0]), .port0_write_memory_mask(p_wm[0]),
    .port0_memory_ready(rdy0), .port0_memory_valid(vld0), .port0_read_memory_data(rd0),
    .port1_memory_enable(p_en[1]), .port1_memory_command(p_cmd[1]),
    .port1_read_memory_address(p_ra[1]), .port1_write_memory_address(p_wa[1]),
    .port1_write_memory_data(p_wd[1]), .port1_write_memory_mask(p_wm[1]),
    .port1_memory_ready(rdy1), .port1_memory_valid(vld1), .port1_read_memory_data(rd1),
    .memory_enable(memory_enable), .memory_command(memory_command),
    .read_memory_address(read_memory_address), .write_memory_address(write_memory_address),
    .write_memory_data(write_memory_data), .write_memory_mask(write_memory_mask),
    .memory_ready(memory_ready), .memory_valid(memory_valid), .read_memory_data(read_memory_data),
    .timeout_error(timeout_error), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cycle_no = 0;
  ev_t  acc_q[$], rsp_q[$], tmo_q[$];
  fwd_t fwd_q[$];
  int   acc_log[$];

  // reference model: one transaction in flight, watchdog count, last winner
  logic m_busy = 1'b0, m_last = 1'b1;
  int   m_owner = 0, m_cnt = 0, m_k = 0, m_lat = 0;
  int   next_lat = 1;
  logic idle_vld = 1'b0, fix_data_en = 1'b0;
  logic [31:0] fix_data = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cycle_no, got, exp);
    end
  endtask

  task automatic miss(input string name, input int cyc);
    n_chk++; n_fail++;
    $display("FAIL %s: expected event at cyc %0d never seen (now %0d)", name, cyc, cycle_no);
  endtask

  task automatic new_req(input int i);
    p_en[i]  = 1'b1;
    p_cmd[i] = ($urandom_range(0, 1) == 1) ? MEMORY_COMMAND_WRITE : MEMORY_COMMAND_READ;
    p_ra[i] = $urandom; p_wa[i] = $urandom; p_wd[i] = $urandom; p_wm[i] = $urandom;
  endtask

  // one clock cycle: drive memory side, predict, queue expectations, advance
  task automatic step();
    int   w, retire;
    ev_t  e;
    fwd_t f;
    logic mv;
    retire = -1;
    mv = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_last = 1'b1;
    end else if (m_busy) begin
      m_k++;
      mv = (m_k == m_lat);
    end else begin
      mv = idle_vld;
    end
    memory_valid = mv;
    read_memory_data = fix_data_en ? fix_data : $urandom;
    f = '{cyc: cycle_no, en: 1'b0, cmd: 1'b0, ra: '0, wa: '0, wd: '0, wm: '0};
    if (!m_busy) begin
      w = -1;
      if (p_en[0] && p_en[1]) w = RR ? (m_last ? 0 : 1) : 0;
      else if (p_en[0])       w = 0;
      else if (p_en[1])       w = 1;
      if (w >= 0) begin
        f.en = 1'b1; f.cmd = p_cmd[w];
        f.ra = p_ra[w]; f.wa = p_wa[w]; f.wd = p_wd[w]; f.wm = p_wm[w];
        if (memory_ready && !reset) begin
          e = '{cyc: cycle_no, port: w, data: '0};
          acc_q.push_back(e);
          m_busy = 1'b1; m_owner = w; m_cnt = 0; m_k = 0; m_lat = next_lat;
          if (RR) m_last = (w == 1);
          retire = w;
        end
      end
    end else begin
      if (mv) begin
        e = '{cyc: cycle_no, port: m_owner, data: read_memory_data};
        rsp_q.push_back(e);
        m_busy = 1'b0;
      end else if (m_cnt == TMO) begin
        e = '{cyc: cycle_no, port: m_owner, data: '0};
        rsp_q.push_back(e);
        e.cyc = cycle_no + 1;
        tmo_q.push_back(e);
        m_busy = 1'b0;
      end else begin
        m_cnt++;
      end
    end
    fwd_q.push_back(f);
    @(posedge clk); #1;
    cycle_no++;
    if (retire >= 0) p_en[retire] = 1'b0;
  endtask

  task automatic idle(input int n);
    p_en[0] = 1'b0; p_en[1] = 1'b0; idle_vld = 1'b0;
    repeat (n) step();
  endtask

  // monitor: mid-cycle sampling, pops expectations when the DUT presents
  always @(negedge clk) begin
    logic [1:0] b;
    fwd_t f;
    ev_t  e;
    while (fwd_q.size() > 0 && fwd_q[0].cyc < cycle_no) begin miss("fwd", fwd_q[0].cyc); void'(fwd_q.pop_front()); end
    if (fwd_q.size() > 0 && fwd_q[0].cyc == cycle_no) begin
      f = fwd_q.pop_front();
      chk("memory_enable", {31'b0, memory_enable}, {31'b0, f.en});
      if (f.en) begin
        chk("memory_command", {31'b0, memory_command}, {31'b0, f.cmd});
        chk("read_address", read_memory_address, f.ra);
        chk("write_address", write_memory_address, f.wa);
        chk("write_data", write_memory_data, f.wd);
        chk("write_mask", write_memory_mask, f.wm);
      end
    end
    while (acc_q.size() > 0 && acc_q[0].cyc < cycle_no) begin miss("accept", acc_q[0].cyc); void'(acc_q.pop_front()); end
    b = {rdy1, rdy0};
    if (acc_q.size() > 0 && acc_q[0].cyc == cycle_no) begin
      e = acc_q.pop_front();
      chk("accept_port", {30'b0, b}, (e.port == 1) ? 32'd2 : 32'd1);
      if (b != 2'b00) acc_log.push_back(b[1] ? 1 : 0);
    end else if (b != 2'b00) begin
      chk("accept_unexpected", {30'b0, b}, 32'd0);
    end
    while (rsp_q.size() > 0 && rsp_q[0].cyc < cycle_no) begin miss("response", rsp_q[0].cyc); void'(rsp_q.pop_front()); end
    b = {vld1, vld0};
    if (rsp_q.size() > 0 && rsp_q[0].cyc == cycle_no) begin
      e = rsp_q.pop_front();
      chk("valid_port", {30'b0, b}, (e.port == 1) ? 32'd2 : 32'd1);
      chk("read_data", b[1] ? rd1 : rd0, e.data);
      chk("owner", {31'b0, owner}, e.port);
    end else if (b != 2'b00) begin
      chk("valid_unexpected", {30'b0, b}, 32'd0);
    end
    while (tmo_q.size() > 0 && tmo_q[0].cyc < cycle_no) begin miss("timeout_error", tmo_q[0].cyc); void'(tmo_q.pop_front()); end
    if (tmo_q.size() > 0 && tmo_q[0].cyc == cycle_no) begin
      void'(tmo_q.pop_front());
      chk("timeout_error", {31'b0, timeout_error}, 32'd1);
    end else if (timeout_error) begin
      chk("timeout_unexpected", {31'b0, timeout_error}, 32'd0);
    end
  end

  initial begin
    int guard;
    reset = 1'b1; memory_ready = 1'b0; memory_valid = 1'b0; read_memory_data = '0;
    for (int i = 0; i < 2; i++) begin
      p_en[i] = 1'b0; p_cmd[i] = 1'b0; p_ra[i] = '0; p_wa[i] = '0; p_wd[i] = '0; p_wm[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_owner", {31'b0, owner}, 32'd0);
    chk("reset_timeout", {31'b0, timeout_error}, 32'd0);
    chk("reset_enable", {31'b0, memory_enable}, 32'd0);
    chk("reset_rdy_vld", {28'b0, rdy1, rdy0, vld1, vld0}, 32'd0);
    reset = 1'b0;
    idle(2);

    // port 0 read 0x100, data 0xDEADBEEF three cycles after accept
    memory_ready = 1'b1; next_lat = 3; fix_data_en = 1'b1; fix_data = 32'hDEADBEEF;
    p_en[0] = 1'b1; p_cmd[0] = MEMORY_COMMAND_READ; p_ra[0] = 32'h100;
    step();
    idle(5);
    fix_data_en = 1'b0;

    // port 1 write held while memory_ready is low for two cycles
    memory_ready = 1'b0; next_lat = 2;
    p_en[1] = 1'b1; p_cmd[1] = MEMORY_COMMAND_WRITE;
    p_wa[1] = 32'h200; p_wd[1] = 32'h12345678; p_wm[1] = 32'h0000FFFF;
    step(); step();
    memory_ready = 1'b1;
    step();
    idle(4);

    // watchdog abort, then a fresh request is accepted
    next_lat = 1000;
    new_req(0); step();
    idle(7);
    next_lat = 2;
    new_req(1); step();
    idle(4);

    // valid on the timeout cycle completes normally
    next_lat = TMO + 1;
    new_req(0); step();
    idle(TMO + 4);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) if (!p_en[i] && $urandom_range(0, 2) == 0) new_req(i);
      memory_ready = ($urandom_range(0, 3) != 0);
      idle_vld = ($urandom_range(0, 9) == 0);
      next_lat = $urandom_range(1, 8);
      step();
    end
    memory_ready = 1'b1;
    idle(12);

    // reset mid-BUSY with port 1 owning, then a stray valid
    next_lat = 1000;
    new_req(1); step();
    step(); step();
    p_en[0] = 1'b0; p_en[1] = 1'b0;
    reset = 1'b1; step(); step();
    reset = 1'b0;
    chk("owner_after_reset", {31'b0, owner}, 32'd0);
    idle_vld = 1'b1; step();
    idle(2);

    // continuous contention
    acc_log.delete();
    next_lat = 1;
    guard = 0;
    while (acc_log.size() < 8 && guard < 100) begin
      for (int i = 0; i < 2; i++) if (!p_en[i]) new_req(i);
      step();
      guard++;
    end
    idle(4);
    chk("contention_count", acc_log.size() >= 8 ? 32'd8 : acc_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++)
      chk("contention_order", acc_log[i], RR ? (i % 2) : 0);

    chk("acc_q_drained", acc_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    chk("tmo_q_drained", tmo_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one memory port between two requesters, typically the `core` (port 0) and a loader/DMA/debug master (port 1), using the core's memory handshake on every side. The block sits between requester memory interfaces and the single memory. It holds at most one outstanding transaction, routes the response to its owner, and aborts a hung transaction with a watchdog.

## Interface
- `TIMEOUT_CYCLES`, 255: busy cycles allowed before abort; 0 disables the watchdog.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `portN_memory_enable` in 1 (N=0,1): request valid.
- `portN_memory_command` in 1: 0 read, 1 write.
- `portN_read_memory_address` in 32: read address.
- `portN_write_memory_address` in 32: write address.
- `portN_write_memory_data` in 32: write data.
- `portN_write_memory_mask` in 32: write bit mask.
- `portN_memory_ready` out 1: request accepted this cycle.
- `portN_memory_valid` out 1: one-cycle completion pulse (read data valid, or write done).
- `portN_read_memory_data` out 32: read data, qualified by `portN_memory_valid`.
- `memory_enable`, `memory_command`, `read_memory_address`, `write_memory_address`, `write_memory_data`, `write_memory_mask` out: downstream request, same widths as above.
- `memory_ready`, `memory_valid`, `read_memory_data` in: downstream acceptance, completion, data.
- `timeout_error` out 1: one-cycle pulse on watchdog abort.
- `owner` out 1: port that owns the in-flight or most recent transaction (debug).

## Operation
- States are IDLE and BUSY.
- **IDLE**
  - Grant logic picks one requesting port combinationally.
  - The granted port's request fields drive the memory outputs. `memory_enable` is the granted port's enable.
  - `portN_memory_ready` equals `memory_ready` for the granted port only. It is 0 for the other port.
  - Accept occurs when `memory_enable && memory_ready`. On accept: `owner` ← granted port, watchdog ← 0, state → BUSY.
- **BUSY**
  - `memory_enable` = 0. Both `portN_memory_ready` = 0.
  - Request fields still drive the owner's values. Requesters hold their fields until ready, not after.
  - On `memory_valid`: pulse `owner_memory_valid` and pass `read_memory_data` to the owner in the same cycle. State → IDLE.
  - `memory_valid` in IDLE is ignored: no port sees valid.
- **Watchdog** (when `TIMEOUT_CYCLES` ≠ 0)
  - The counter increments each BUSY cycle without `memory_valid`.
  - When the count reaches `TIMEOUT_CYCLES`, with no valid that cycle: pulse owner valid with read data 0, pulse `timeout_error`, state → IDLE.
  - `memory_valid` wins over timeout in the same cycle.
  - The counter is 8 bits or wider, sized by `$clog2(TIMEOUT_CYCLES+1)`, and saturates.
- **Grant**
  - A single requester always wins.
  - On contention, see Configuration.
  - The last-winner pointer updates on accept only.
- **Reset** (any time, including mid-BUSY)
  - State IDLE, `owner` 0, counter 0, last winner 1 (so port 0 wins first).
  - The in-flight transaction is dropped and no valid is generated.

## Timing
- Request path IDLE→memory is combinational, with zero added latency.
- Response path is combinational: owner valid and data appear in the same cycle as `memory_valid`.
- Minimum spacing between accepts is 2 cycles: the accept cycle plus at least one BUSY cycle. The next accept is possible in the cycle after valid.
- Registered outputs after reset: `owner`=0, `timeout_error`=0.
- Combinational outputs after reset: all `portN_memory_ready`/`valid`=0 and `memory_enable`=0 unless a request is present.

## Configuration
- `MEMORY_ARBITER_ROUND_ROBIN_EN` defined: on contention, the port that did not win the last accept wins.
- Undefined: fixed priority, port 0 always wins. The last-winner register is omitted and port 1 can starve.

## Structure
- `memory_arbiter_pkg` holds:
  - the state enum (`IDLE`, `BUSY`);
  - command constants `MEMORY_COMMAND_READ`=0 and `MEMORY_COMMAND_WRITE`=1;
  - the port-index type.
- Sub-module `arbiter_grant`: combinational 2-way grant taking requests and the last winner, producing a one-hot grant. The macro is applied inside it.

## Test plan
- Port 0 only reads 0x100 while memory is ready, with valid 3 cycles later returning 0xDEADBEEF → `port0_memory_valid` pulses once with 0xDEADBEEF and port 1 sees nothing.
- Both ports request continuously → with RR, accepts alternate 0,1,0,1. With the macro undefined, all accepts go to port 0.
- Port 1 write of data 0x12345678, mask 0x0000FFFF, address 0x200 while `memory_ready` is low for 2 cycles → the fields are forwarded unchanged and `port1_memory_ready` rises only with `memory_ready`.
- `TIMEOUT_CYCLES`=4 and memory never sends valid → `timeout_error` and owner valid pulse after 4 BUSY cycles with data 0, then a new request is accepted.
- `memory_valid` arrives on the timeout cycle → normal completion and no `timeout_error`.
- `reset` asserted mid-BUSY, then `memory_valid` pulses → no port valid, state IDLE, and port 0 wins the next contention.
